alu_operand_ctrl: RTL and testbench

//   Execute-stage controller directly upstream of alu_sch. Accepts one instruction per

---
 rtl/alu_operand_ctrl.sv | 157 +++++++++++++++
 tb/tb_alu_operand_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_ctrl.sv
// rtl/alu_operand_ctrl.sv - execute-stage operand/writeback controller feeding an external combinational ALU
// Optional zero flag output ZERO is built when ZFLAG_EN is defined.
module alu_operand_ctrl #(
    parameter int DW   = 8,
    parameter int NREG = 4,
    parameter int AW   = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          INSTR_VALID,
    output logic          INSTR_READY,
    input  logic [1:0]    OPC,
    input  logic [AW-1:0] RD,
    input  logic [AW-1:0] RS1,
    input  logic [AW-1:0] RS2,
    input  logic [DW-1:0] IMM,
    output logic [DW-1:0] X,
    output logic [DW-1:0] Y,
    output logic          SEL,
    input  logic [DW-1:0] DATA_OUT,
    input  logic          Cnext,
    output logic          CARRY,
    output logic [DW-1:0] RESULT,
    output logic          DONE,
`ifdef ZFLAG_EN
    output logic          ZERO,
`endif
    input  logic [AW-1:0] DBG_ADDR,
    output logic [DW-1:0] DBG_DATA
);

    localparam logic [1:0] OPC_ADD = 2'b00;
    localparam logic [1:0] OPC_SUB = 2'b01;
    localparam logic [1:0] OPC_LDI = 2'b10;
    localparam logic [1:0] OPC_NOP = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          w_ready;
    logic          w_accept;

    logic [DW-1:0] r_rf [NREG];
    logic [DW-1:0] r_x;
    logic [DW-1:0] r_y;
    logic          r_sel;
    logic          r_carry;
    logic [DW-1:0] r_result;
    logic          r_done;
    logic [1:0]    r_opc;
    logic [AW-1:0] r_rd;
    logic [DW-1:0] r_imm;
`ifdef ZFLAG_EN
    logic          r_zero;
`endif

    assign w_accept = INSTR_VALID & w_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (OPC == OPC_ADD || OPC == OPC_SUB) begin
                        w_next = S_EXEC;
                    end else begin
                        w_next = S_WB;
                    end
                end
            end
            S_EXEC:  w_next = S_WB;
            S_WB:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ready = (r_state == S_IDLE);
    end

    // X/Y/SEL only load on an ALU accept, so they stay stable through the settle cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
            r_x      <= '0;
            r_y      <= '0;
            r_sel    <= 1'b0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_opc    <= OPC_NOP;
            r_rd     <= '0;
            r_imm    <= '0;
`ifdef ZFLAG_EN
            r_zero   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_opc <= OPC;
                r_rd  <= RD;
                r_imm <= IMM;
                if (OPC == OPC_ADD || OPC == OPC_SUB) begin
                    r_x   <= r_rf[RS1];
                    r_y   <= r_rf[RS2];
                    r_sel <= OPC[0];
                end
            end
            if (r_state == S_WB) begin
                r_done <= 1'b1;
                case (r_opc)
                    OPC_ADD, OPC_SUB: begin
                        r_rf[r_rd] <= DATA_OUT;
                        r_result   <= DATA_OUT;
                        r_carry    <= Cnext;
`ifdef ZFLAG_EN
                        r_zero     <= (DATA_OUT == '0);
`endif
                    end
                    OPC_LDI: begin
                        r_rf[r_rd] <= r_imm;
                        r_result   <= r_imm;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign INSTR_READY = w_ready;
    assign X           = r_x;
    assign Y           = r_y;
    assign SEL         = r_sel;
    assign CARRY       = r_carry;
    assign RESULT      = r_result;
    assign DONE        = r_done;
    assign DBG_DATA    = r_rf[DBG_ADDR];
`ifdef ZFLAG_EN
    assign ZERO        = r_zero;
`endif

endmodule

// File: tb/tb_alu_operand_ctrl.sv
// tb/tb_alu_operand_ctrl.sv - directed-vector bench for alu_operand_ctrl with an ALU model attached
module tb_alu_operand_ctrl;

    localparam int DW = 8;
    localparam int AW = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          INSTR_VALID = 1'b0;
    logic          INSTR_READY;
    logic [1:0]    OPC = 2'b11;
    logic [AW-1:0] RD = '0;
    logic [AW-1:0] RS1 = '0;
    logic [AW-1:0] RS2 = '0;
    logic [DW-1:0] IMM = '0;
    logic [DW-1:0] X;
    logic [DW-1:0] Y;
    logic          SEL;
    logic [DW-1:0] DATA_OUT;
    logic          Cnext;
    logic          CARRY;
    logic [DW-1:0] RESULT;
    logic          DONE;
    logic [AW-1:0] DBG_ADDR = '0;
    logic [DW-1:0] DBG_DATA;
`ifdef ZFLAG_EN
    logic          ZERO;
`endif

    int n_vec = 0;
    int n_err = 0;
    int n_done = 0;

    always #5 CLK = ~CLK;

    // Combinational ALU: SEL=0 add, SEL=1 subtract via X + ~Y + 1
    assign {Cnext, DATA_OUT} = {1'b0, X} + {1'b0, (SEL ? ~Y : Y)} + {{DW{1'b0}}, SEL};

    alu_operand_ctrl #(.DW(DW), .NREG(4), .AW(AW)) dut (
        .CLK(CLK), .RST(RST),
        .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
        .OPC(OPC), .RD(RD), .RS1(RS1), .RS2(RS2), .IMM(IMM),
        .X(X), .Y(Y), .SEL(SEL),
        .DATA_OUT(DATA_OUT), .Cnext(Cnext),
        .CARRY(CARRY), .RESULT(RESULT), .DONE(DONE),
`ifdef ZFLAG_EN
        .ZERO(ZERO),
`endif
        .DBG_ADDR(DBG_ADDR), .DBG_DATA(DBG_DATA)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        if (DONE === 1'b1) n_done++;
    endtask

    task automatic drive(input logic [1:0] opc, input logic [AW-1:0] rd,
                         input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [DW-1:0] imm);
        INSTR_VALID = 1'b1;
        OPC = opc; RD = rd; RS1 = rs1; RS2 = rs2; IMM = imm;
    endtask

    task automatic do_ldi(input string tag, input logic [AW-1:0] rd, input logic [DW-1:0] imm);
        check({tag, "_ready"}, INSTR_READY, 1);
        drive(2'b10, rd, '0, '0, imm);
        tick();
        INSTR_VALID = 1'b0;
        check({tag, "_busy"}, INSTR_READY, 0);
        check({tag, "_done_lo"}, DONE, 0);
        DBG_ADDR = rd;
        tick();
        check({tag, "_done_hi"}, DONE, 1);
        check({tag, "_result"}, RESULT, imm);
        check({tag, "_rf"}, DBG_DATA, imm);
    endtask

    task automatic do_alu(input string tag, input logic [1:0] opc, input logic [AW-1:0] rd,
                          input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                          input logic [DW-1:0] ex, input logic [DW-1:0] ey,
                          input logic [DW-1:0] eres, input logic ecarry);
        drive(opc, rd, rs1, rs2, 8'h5A);
        tick();
        INSTR_VALID = 1'b0;
        check({tag, "_x"}, X, ex);
        check({tag, "_y"}, Y, ey);
        check({tag, "_sel"}, SEL, opc[0]);
        check({tag, "_exec_busy"}, INSTR_READY, 0);
        tick();
        check({tag, "_wb_busy"}, INSTR_READY, 0);
        check({tag, "_wb_done_lo"}, DONE, 0);
        DBG_ADDR = rd;
        tick();
        check({tag, "_done_hi"}, DONE, 1);
        check({tag, "_ready"}, INSTR_READY, 1);
        check({tag, "_result"}, RESULT, eres);
        check({tag, "_carry"}, CARRY, ecarry);
        check({tag, "_rf"}, DBG_DATA, eres);
    endtask

    initial begin
        // 1: reset
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        for (int a = 0; a < 4; a++) begin
            DBG_ADDR = a[AW-1:0];
            #1;
            check($sformatf("rst_rf%0d", a), DBG_DATA, 0);
        end
        check("rst_carry", CARRY, 0);
        check("rst_done", DONE, 0);
        check("rst_ready", INSTR_READY, 1);
        check("rst_result", RESULT, 0);
        check("rst_x", X, 0);
`ifdef ZFLAG_EN
        check("rst_zero", ZERO, 0);
`endif

        // 2: simple add
        do_ldi("t2_ldi1", 2'd1, 8'h11);
        do_ldi("t2_ldi2", 2'd2, 8'h11);
        do_alu("t2_add", 2'b00, 2'd3, 2'd1, 2'd2, 8'h11, 8'h11, 8'h22, 1'b0);
`ifdef ZFLAG_EN
        check("t2_zero", ZERO, 0);
`endif

        // 3: wrap to zero with carry
        do_ldi("t3_ldi0", 2'd0, 8'hFF);
        do_ldi("t3_ldi1", 2'd1, 8'h01);
        do_alu("t3_add", 2'b00, 2'd2, 2'd0, 2'd1, 8'hFF, 8'h01, 8'h00, 1'b1);
`ifdef ZFLAG_EN
        check("t3_zero", ZERO, 1);
`endif

        // 4: subtract; LDI must leave CARRY alone
        do_ldi("t4_ldi0", 2'd0, 8'hAA);
        check("t4_carry_kept", CARRY, 1);
`ifdef ZFLAG_EN
        check("t4_zero_kept", ZERO, 1);
`endif
        do_ldi("t4_ldi1", 2'd1, 8'h55);
        do_alu("t4_sub", 2'b01, 2'd2, 2'd0, 2'd1, 8'hAA, 8'h55, 8'h55, 1'b1);

        // 5: VALID held high across two ADDs; second reads R3 written by the first
        n_done = 0;
        drive(2'b00, 2'd3, 2'd1, 2'd2, 8'h00);
        tick();                                   // edge k: accept ADD R3,R1,R2
        drive(2'b00, 2'd0, 2'd3, 2'd1, 8'h00);    // ADD R0,R3,R1 waits with VALID high
        check("t5_exec_busy", INSTR_READY, 0);
        check("t5_x1", X, 8'h55);
        tick();                                   // k+1
        check("t5_wb_busy", INSTR_READY, 0);
        check("t5_x1_held", X, 8'h55);
        DBG_ADDR = 2'd3;
        tick();                                   // k+2: write R3
        check("t5_done1", DONE, 1);
        check("t5_ready", INSTR_READY, 1);
        check("t5_r3", DBG_DATA, 8'hAA);
        tick();                                   // k+3: second accept
        INSTR_VALID = 1'b0;
        check("t5_x2", X, 8'hAA);
        check("t5_y2", Y, 8'h55);
        check("t5_busy2", INSTR_READY, 0);
        tick();
        DBG_ADDR = 2'd0;
        tick();                                   // k+5: write R0
        check("t5_done2", DONE, 1);
        check("t5_r0", DBG_DATA, 8'hFF);
        check("t5_carry", CARRY, 0);
        tick();
        tick();
        tick();
        check("t5_done_count", n_done, 2);

        // NOP retires with no writes
        drive(2'b11, 2'd0, 2'd0, 2'd0, 8'h12);
        tick();
        INSTR_VALID = 1'b0;
        check("nop_busy", INSTR_READY, 0);
        tick();
        check("nop_done", DONE, 1);
        check("nop_result", RESULT, 8'hFF);
        check("nop_r0", DBG_DATA, 8'hFF);
        tick();
        check("nop_done_lo", DONE, 0);

        // 6: reset during EXEC aborts the ADD
        n_done = 0;
        drive(2'b00, 2'd3, 2'd1, 2'd2, 8'h00);
        tick();
        INSTR_VALID = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        DBG_ADDR = 2'd3;
        #1;
        check("t6_ready", INSTR_READY, 1);
        check("t6_done", DONE, 0);
        check("t6_r3", DBG_DATA, 0);
        check("t6_result", RESULT, 0);
        tick();
        tick();
        check("t6_no_done", n_done, 0);
        check("t6_r3_late", DBG_DATA, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
